// File: rtl/result_tx_control.sv
// Return-path framer: captures an operation code and a 16-bit result, then sends
// {HEADER, operation, result[15:8], result[7:0]} to the UART TX with a per-byte ack timeout.
module result_tx_control #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        result_valid,
  input  logic [7:0]  operation,
  input  logic [15:0] result,
  input  logic        tx_busy,
  output logic        ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_done,
  output logic        tx_error
);
  // state     | meaning
  // IDLE      | ready for a new frame request
  // ISSUE     | waiting for the UART to be free, then start byte_idx
  // WAIT_ACK  | tx_start issued, waiting for tx_busy to rise
  // WAIT_DONE | UART serializing, waiting for tx_busy to fall
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  localparam int            TW         = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  state_t          state;
  logic [1:0]      byte_idx;
  logic [TW-1:0]   timer;
  logic [3:0][7:0] frame_buf;

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      frame_done <= 1'b0;
      tx_error   <= 1'b0;
      byte_idx   <= 2'd0;
      timer      <= '0;
      frame_buf  <= '0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (result_valid) begin
            frame_buf <= {result[7:0], result[15:8], operation, HEADER};
            byte_idx  <= 2'd0;
            tx_error  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= frame_buf[byte_idx];
            timer    <= '0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // busy already high in the tx_start cycle counts as the acknowledge
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TIMER_LAST) begin
            tx_error <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (byte_idx == 2'd3) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_tx_control.sv
// Scoreboard bench for result_tx_control: expected bytes are queued by the stimulus,
// a negedge monitor pops and compares them at every tx_start.
module tb_result_tx_control;
  localparam logic [7:0] HDR      = 8'hA5;
  localparam int         ACK_TO   = 16;
  localparam int         BUSY_LEN = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        result_valid = 1'b0;
  logic [7:0]  operation = 8'h00;
  logic [15:0] result = 16'h0000;
  logic        tx_busy;
  logic        ready, tx_start, frame_done, tx_error;
  logic [7:0]  tx_data;

  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  int   busy_cnt = 0;
  int   mute_at = -1;
  int   cyc = 0;
  int   n_starts = 0;
  int   n_done = 0;
  int   done_exp = 0;
  int   start_cycs[$];
  logic [7:0] exp_q[$];
  logic prev_start = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  assign tx_busy = model_busy | force_busy;

  always #10 clk = ~clk;

  result_tx_control #(.HEADER(HDR), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset), .result_valid(result_valid), .operation(operation),
    .result(result), .tx_busy(tx_busy), .ready(ready), .tx_start(tx_start),
    .tx_data(tx_data), .frame_done(frame_done), .tx_error(tx_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy rises one cycle after tx_start and stays high BUSY_LEN cycles
  always @(posedge clk) begin
    if (tx_start === 1'b1 && (n_starts - 1) != mute_at) begin
      model_busy <= 1'b1;
      busy_cnt   <= BUSY_LEN;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end
  end

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      n_starts++;
      start_cycs.push_back(cyc);
      check("start_not_consecutive", 32'(prev_start), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx_start: got data %0h, expected no byte", tx_data);
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (frame_done === 1'b1) begin
      n_done++;
      if (done_exp == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        done_exp--;
        check("ready_in_done_cycle", 32'(ready), 1);
      end
    end
    prev_start = (tx_start === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] op, input logic [15:0] res, input int nbytes,
                            input bit done);
    logic [7:0] b[4];
    b[0] = HDR;
    b[1] = op;
    b[2] = res[15:8];
    b[3] = res[7:0];
    for (int i = 0; i < nbytes; i++) exp_q.push_back(b[i]);
    if (done) done_exp++;
  endtask

  task automatic accept(input logic [7:0] op, input logic [15:0] res, input bit change,
                        output int c);
    @(negedge clk);
    #1;
    result_valid = 1'b1;
    operation    = op;
    result       = res;
    c            = cyc;
    @(negedge clk);
    #1;
    result_valid = 1'b0;
    if (change) begin
      operation = 8'hFF;
      result    = 16'hFFFF;
    end
  endtask

  task automatic wait_done(input string name, input int limit, output int d);
    bit seen = 1'b0;
    bit rdy_bad = 1'b0;
    d = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      #1;
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        d    = cyc;
      end else if (ready !== 1'b0) begin
        rdy_bad = 1'b1;
      end
    end
    check({name, "_frame_done_seen"}, 32'(seen), 1);
    check({name, "_ready_low_in_frame"}, 32'(rdy_bad), 0);
  endtask

  task automatic wait_starts(input string name, input int target, input int limit);
    int i = 0;
    while (n_starts < target && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    check({name, "_start_seen"}, 32'(n_starts >= target), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, 32'(ready), 1);
    check({name, "_tx_start"}, 32'(tx_start), 0);
    check({name, "_tx_data"}, 32'(tx_data), 0);
    check({name, "_frame_done"}, 32'(frame_done), 0);
    check({name, "_tx_error"}, 32'(tx_error), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, s, base, dn;
    bit err_seen;

    cycles(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    cycles(2);

    // normal frame with latency and byte-gap checks
    base = n_starts;
    push_frame(8'h2B, 16'h1234, 4, 1'b1);
    accept(8'h2B, 16'h1234, 1'b0, c);
    check("t1_ready_low_after_accept", 32'(ready), 0);
    wait_done("t1", 200, d);
    check("t1_first_start_latency", start_cycs[base] - c, 2);
    for (int i = 1; i < 4; i++)
      check("t1_byte_gap", start_cycs[base+i] - start_cycs[base+i-1], BUSY_LEN + 3);
    check("t1_done_latency", d - start_cycs[base+3], BUSY_LEN + 2);
    cycles(2);

    // inputs change the cycle after accept
    push_frame(8'h2B, 16'h1234, 4, 1'b1);
    accept(8'h2B, 16'h1234, 1'b1, c);
    wait_done("t2", 200, d);
    cycles(2);

    // UART busy before the first issue
    base = n_starts;
    push_frame(8'h5C, 16'hBEEF, 4, 1'b1);
    @(negedge clk);
    #1;
    force_busy   = 1'b1;
    result_valid = 1'b1;
    operation    = 8'h5C;
    result       = 16'hBEEF;
    c            = cyc;
    @(negedge clk);
    #1;
    result_valid = 1'b0;
    cycles(5);
    check("t3_no_start_while_busy", n_starts - base, 0);
    force_busy = 1'b0;
    wait_done("t3", 200, d);
    check("t3_start_after_busy_falls", start_cycs[base] - c, 7);
    cycles(2);

    // acknowledge timeout on the second byte
    base    = n_starts;
    dn      = n_done;
    mute_at = base + 1;
    push_frame(8'h77, 16'h0F0F, 2, 1'b0);
    accept(8'h77, 16'h0F0F, 1'b0, c);
    wait_starts("t4", base + 2, 100);
    s = start_cycs[base+1];
    err_seen = 1'b0;
    for (int i = 0; i < 100 && !err_seen; i++) begin
      if (tx_error === 1'b1) err_seen = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    check("t4_error_seen", 32'(err_seen), 1);
    check("t4_error_latency", cyc - s, ACK_TO);
    check("t4_ready_after_timeout", 32'(ready), 1);
    cycles(5);
    check("t4_error_sticky", 32'(tx_error), 1);
    check("t4_no_frame_done", n_done - dn, 0);
    mute_at = -1;
    push_frame(8'h01, 16'hCAFE, 4, 1'b1);
    accept(8'h01, 16'hCAFE, 1'b0, c);
    check("t4_error_cleared_on_accept", 32'(tx_error), 0);
    wait_done("t4b", 200, d);
    cycles(2);

    // reset while byte 3 is on the wire
    base = n_starts;
    push_frame(8'h3C, 16'hA1B2, 3, 1'b0);
    accept(8'h3C, 16'hA1B2, 1'b0, c);
    wait_starts("t5", base + 3, 100);
    cycles(3);
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    check_reset_outputs("t5_after_reset");
    push_frame(8'h9A, 16'h5678, 4, 1'b1);
    accept(8'h9A, 16'h5678, 1'b0, c);
    wait_done("t5b", 200, d);
    cycles(2);

    // back-to-back frames with result_valid held high
    base = n_starts;
    push_frame(8'h11, 16'h0001, 4, 1'b1);
    push_frame(8'h11, 16'h0002, 4, 1'b1);
    @(negedge clk);
    #1;
    result_valid = 1'b1;
    operation    = 8'h11;
    result       = 16'h0001;
    @(negedge clk);
    #1;
    result = 16'h0002;
    wait_done("t6a", 200, d);
    @(negedge clk);
    #1;
    result_valid = 1'b0;
    wait_done("t6b", 200, dn);
    check("t6_second_frame_start", start_cycs[base+4] - d, 2);
    check("t6_byte_count", n_starts - base, 8);
    cycles(3);

    check("scoreboard_bytes_drained", exp_q.size(), 0);
    check("scoreboard_done_drained", done_exp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
